memoria_dados: RTL and testbench
================================

Name: memoria_dados

Overview:
Data-memory responder on the polirv core's data port. It is the slave end of the d_mem_we / d_mem_addr / d_mem_data interface.
- Stores DEPTH words of DATA_W bits.
- Samples write data from the shared bidirectional bus on we=1.
- Drives read data onto the bus on we=0.
- After every reset, runs a sequential clear of the whole array and flags busy until the clear is done.

Parameters:
ADDR_W, 6, address width (matches d_mem_addr)
DATA_W, 64, word width (matches d_mem_data)
DEPTH, 64, number of words; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
we  input  1  write enable from core (d_mem_we)
ads  input  ADDR_W  word address from core (d_mem_addr)
data  inout  DATA_W  shared data bus (d_mem_data)
busy  output  1  1 while clear sequence runs; core must not access memory

Behaviour:
- Single clock domain. One clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk, and overrides every other input.
- Reset values:
  - state=CLEAR
  - clr_ptr=0
  - busy=1
  - data bus released (all bits Z)
  - array contents are don't-care until the clear completes.
- FSM states: CLEAR and READY.
- CLEAR:
  - Each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - When clr_ptr==DEPTH-1, that word is written, clr_ptr wraps to 0 and state goes to READY on the same edge.
  - Exactly DEPTH clock edges after reset deasserts, busy=0.
  - we, ads and data are ignored. The memory never drives the bus.
- READY, busy=0:
  - we=1: memory releases the bus (Z, combinationally from we). On the rising edge, mem[ads] <= data. No other word changes.
  - we=0: memory drives data = mem[ads] combinationally (asynchronous read, zero-cycle latency, follows ads within the same cycle).
  - Read-after-write: a read of address A in the cycle after a write to A returns the new value. There is no write-through to the bus in the write cycle itself.
- Bus contention: the memory drives only when state==READY && we==0 && rst==0. The core must drive only when we==1.
- Address: full ADDR_W decode, no aliasing. Address DEPTH-1 is valid. No out-of-range case exists because DEPTH==2**ADDR_W.
- Reset mid-clear: the clear restarts from clr_ptr=0 and busy stays 1. Total time is DEPTH cycles from the last reset edge.
- Reset during READY:
  - Returns to CLEAR.
  - A write coinciding with the reset edge is dropped.
  - All contents are zeroed by the new clear.
- X/Z on we in READY: treated as 0 is not guaranteed. The bench must keep we at a known level.

Test Plan:
1. Clear timing: assert rst 2 cycles then release -> busy=1 for exactly 64 rising edges after release, busy=0 on edge 64. Bus is Z throughout. Subsequently reading ads=0, 31 and 63 returns 64'h0.
2. Write/read: in READY, we=1, ads=6'd5, bench drives 64'hDEADBEEF_CAFEF00D for one cycle. Then we=0 and bench releases -> next cycle data=64'hDEADBEEF_CAFEF00D. Reading ads=6'd4 still returns 0.
3. Boundary address and bus release:
   - Write 64'hFFFF_FFFF_FFFF_FFFF to ads=63 and 64'h1 to ads=0, then read both -> correct values, no aliasing.
   - During every we=1 cycle the memory's driver is Z. Check with a weak pull on the bus: bus equals the bench value, never X.
4. Access during clear: 10 cycles after rst release, drive we=1, ads=3, data=64'h1234 -> ignored. After busy falls, ads=3 reads 64'h0.
5. Reset mid-clear: pulse rst again at clear cycle 40 -> busy stays 1 and falls exactly 64 edges after the second release.
6. Reset in READY with data:
   - Write 64'hA5A5 to ads=7.
   - Assert rst on the same edge as a write of 64'h5A5A to ads=8.
   - Result: busy returns to 1, and after the clear both ads=7 and ads=8 read 64'h0.

Source files
------------

// File: rtl/memoria_dados.sv
// memoria_dados: data-memory responder on the core's data port.
//
// Stores DEPTH words of DATA_W bits. After every reset it zeroes the whole
// array one word per clock and raises busy until the last word is cleared.
// Once ready, it reads asynchronously (drives the bus while we=0) and writes
// synchronously (samples the bus on the rising edge while we=1).
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - synchronous reset, active-high, overrides every other input
//   we   - write enable from the core (d_mem_we)
//   ads  - word address from the core (d_mem_addr)
//   data - shared bidirectional data bus (d_mem_data)
//   busy - 1 while the clear sequence runs; the core must not access memory
module memoria_dados #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] ads,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_HIZ  = {DATA_W{1'bz}};

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [ADDR_W-1:0]   clr_ptr_d;
  logic                busy_q;
  logic                busy_d;

  // Single write port shared by the clear sequence and core writes.
  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;

  logic                drive_en_s;
  logic [DATA_W-1:0]   rd_data_s;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // State register: FSM state, clear pointer and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= ADDR_ZERO;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: walk the clear pointer, leave CLEAR after the last word.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (rst) begin
      state_d   = ST_CLEAR;
      clr_ptr_d = ADDR_ZERO;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_ptr_q == LAST_ADDR) begin
            state_d   = ST_READY;
            clr_ptr_d = ADDR_ZERO;
          end else begin
            state_d   = ST_CLEAR;
            clr_ptr_d = clr_ptr_q + ADDR_ONE;
          end
        end
        ST_READY: begin
          state_d   = ST_READY;
          clr_ptr_d = clr_ptr_q;
        end
        default: begin
          state_d   = ST_CLEAR;
          clr_ptr_d = ADDR_ZERO;
        end
      endcase
    end
  end

  // Output logic: write-port selection and the busy value for the next cycle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = ADDR_ZERO;
    wr_data_d = DATA_ZERO;
    busy_d    = 1'b1;
    if (state_d == ST_READY) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
    // A reset edge drops any coinciding write; the new clear rewrites everything.
    if (rst) begin
      wr_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_ptr_q;
          wr_data_d = DATA_ZERO;
        end
        ST_READY: begin
          wr_en_d   = we;
          wr_addr_d = ads;
          wr_data_d = data;
        end
        default: begin
          wr_en_d = 1'b0;
        end
      endcase
    end
  end

  // Storage array: one write per clock, no reset (contents defined by the clear).
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  // Asynchronous read; the bus is driven only when ready, reading, and not in reset.
  always_comb begin
    rd_data_s  = mem_q[ads];
    drive_en_s = (state_q == ST_READY) && !we && !rst;
  end

  assign data = drive_en_s ? rd_data_s : DATA_HIZ;
  assign busy = busy_q;

endmodule

// File: tb/tb_memoria_dados.sv
module tb_memoria_dados;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] ads;
  logic              drv_en;
  logic [DATA_W-1:0] drv_val;
  wire  [DATA_W-1:0] data_bus;
  wire               busy;

  int checks = 0;
  int errors = 0;

  // Reference model: word contents as seen once ready, and remaining clear edges.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                clear_left = 0;

  assign data_bus = drv_en ? drv_val : {DATA_W{1'bz}};

  memoria_dados #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .ads  (ads),
    .data (data_bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge: update the model from the sampled inputs, then check busy.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (we) begin
      model_mem[ads] = drv_val;
    end
    #1;
    chk("busy", {63'd0, busy}, (clear_left != 0) ? 64'd1 : 64'd0);
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [63:0] exp);
    rst = 1'b0; we = 1'b0; drv_en = 1'b0; ads = a;
    #1;
    chk(tag, data_bus, exp);
    step();
  endtask

  task automatic wr(input string tag, input logic [ADDR_W-1:0] a, input logic [63:0] v);
    rst = 1'b0; we = 1'b1; drv_en = 1'b1; drv_val = v; ads = a;
    #1;
    chk(tag, data_bus, v);
    step();
  endtask

  // Runs a clear from reset release until busy falls; optional poke/probe/reset.
  task automatic run_clear(input string tag, input int rst_at, input int poke_at, input int probe_until);
    int n = 0;
    bit did_rst = 1'b0;
    while (n < 200) begin
      rst = 1'b0; we = 1'b0; drv_en = 1'b0;
      if (!did_rst && n == rst_at) begin
        rst = 1'b1;
        step();
        did_rst = 1'b1;
        n = 0;
        continue;
      end
      if (n == poke_at) begin
        we = 1'b1; drv_en = 1'b1; ads = 6'd3; drv_val = 64'h1234;
        #1;
        chk("poke_bus", data_bus, 64'h1234);
      end else if (n < probe_until) begin
        ads = 6'd7; drv_en = 1'b1; drv_val = 64'h0;
        #1;
        chk("clear_release", data_bus, 64'h0);
      end
      step();
      n++;
      if (busy === 1'b0) break;
    end
    chk(tag, 64'(n), 64'd64);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; ads = '0; drv_en = 1'b0; drv_val = '0;

    // Test 1 + 4: reset for two cycles, clear length, ignored access at cycle 10.
    step();
    step();
    run_clear("clear_len", -1, 10, 0);
    rd("rd0_zero", 6'd0, 64'h0);
    rd("rd31_zero", 6'd31, 64'h0);
    rd("rd63_zero", 6'd63, 64'h0);
    rd("rd3_ignored", 6'd3, 64'h0);

    // Test 2: write then read-after-write.
    wr("wr5_bus", 6'd5, 64'hDEADBEEF_CAFEF00D);
    rd("rd5", 6'd5, 64'hDEADBEEF_CAFEF00D);
    rd("rd4_zero", 6'd4, 64'h0);

    // Test 3: boundary addresses, no aliasing, bus released on writes.
    wr("wr63_bus", 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    wr("wr0_bus", 6'd0, 64'h1);
    rd("rd63", 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("rd0", 6'd0, 64'h1);
    rd("rd31_alias", 6'd31, 64'h0);
    rd("rd5_keep", 6'd5, 64'hDEADBEEF_CAFEF00D);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      logic [ADDR_W-1:0] a;
      logic [63:0] v;
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      v = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) wr("rnd_wr_bus", a, v);
      else rd("rnd_rd", a, model_mem[a]);
    end
    for (int k = 0; k < DEPTH; k++) rd("sweep", ADDR_W'(k), model_mem[k]);

    // Test 6 + 5: reset in READY with a coinciding write, then reset mid-clear.
    wr("wr7_bus", 6'd7, 64'hA5A5);
    rd("rd7", 6'd7, 64'hA5A5);
    rst = 1'b1; we = 1'b1; drv_en = 1'b1; drv_val = 64'h5A5A; ads = 6'd8;
    #1;
    chk("rst_wr_bus", data_bus, 64'h5A5A);
    step();
    run_clear("reclear_len", 40, -1, 6);
    rd("rd7_cleared", 6'd7, 64'h0);
    rd("rd8_dropped", 6'd8, 64'h0);
    for (int k = 0; k < DEPTH; k++) rd("sweep_zero", ADDR_W'(k), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
